// File: rtl/branch_predict_resolve.sv
// Branch predictor with EX-stage resolution: 2-bit saturating counters indexed by PC,
// combinational misprediction flush/redirect, and resolved/mispredicted branch statistics.
module branch_predict_resolve #(
    parameter int         INDEX_W  = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_ID,
    input  logic [31:0] pc_ID,
    input  logic [31:0] imm_data_ID,
    output logic        BP_ID,
    output logic [31:0] pred_target_ID,
    input  logic        branch_EX,
    input  logic        BP_EX,
    input  logic [31:0] pc_EX,
    input  logic [31:0] imm_data_EX,
    input  logic [2:0]  fun3_EX,
    input  logic [31:0] opA_EX,
    input  logic [31:0] opB_EX,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    logic [1:0]         table_q [ENTRIES];
    logic [1:0]         table_d [ENTRIES];
    logic [31:0]        branch_cnt_q, branch_cnt_d;
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;
    logic [INDEX_W-1:0] idx_id, idx_ex;
    logic signed [31:0] opa_s, opb_s;
    logic               taken_ex;

    assign idx_id = pc_ID[INDEX_W+1:2];
    assign idx_ex = pc_EX[INDEX_W+1:2];

    // Lookup reads the registered table only, so a same-cycle update is not visible here.
    always_comb begin
        BP_ID          = branch_ID & table_q[idx_id][1];
        pred_target_ID = BP_ID ? (pc_ID + imm_data_ID) : (pc_ID + 32'd4);
    end

    always_comb begin
        opa_s    = opA_EX;
        opb_s    = opB_EX;
        taken_ex = 1'b0;
        case (fun3_EX)
            3'b000:  taken_ex = (opA_EX == opB_EX);
            3'b001:  taken_ex = (opA_EX != opB_EX);
            3'b100:  taken_ex = (opa_s < opb_s);
            3'b101:  taken_ex = (opa_s >= opb_s);
            3'b110:  taken_ex = (opA_EX < opB_EX);
            3'b111:  taken_ex = (opA_EX >= opB_EX);
            default: taken_ex = 1'b0;
        endcase
    end

    always_comb begin
        flush       = branch_EX & (taken_ex != BP_EX);
        redirect_pc = taken_ex ? (pc_EX + imm_data_EX) : (pc_EX + 32'd4);
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (branch_EX) begin
            table_d[idx_ex] = taken_ex ? sat_inc2(table_q[idx_ex]) : sat_dec2(table_q[idx_ex]);
            branch_cnt_d    = sat_inc32(branch_cnt_q);
        end
        if (flush) begin
            mispred_cnt_d = sat_inc32(mispred_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CNT_INIT;
            end
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
